// File: rtl/reg_bank_seq.sv
// Two-register bank with a one-command-at-a-time sequencer that loads, presents,
// moves, swaps and clears R0/R1, driving the select of the downstream output mux.
module reg_bank_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] FROM_BUS,
    input  logic             CMD_VALID,
    input  logic [2:0]       CMD,
    output logic             CMD_READY,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic             SEL_BUS,
    output logic             BUS_EN,
    output logic             DONE,
    output logic [CNT_W-1:0] OP_COUNT
);

    typedef enum logic [1:0] {IDLE, EXEC, SWAP_A, SWAP_B} state_t;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOAD_R0 = 3'b001;
    localparam logic [2:0] OP_LOAD_R1 = 3'b010;
    localparam logic [2:0] OP_OUT_R0  = 3'b011;
    localparam logic [2:0] OP_OUT_R1  = 3'b100;
    localparam logic [2:0] OP_MOV     = 3'b101;
    localparam logic [2:0] OP_SWAP    = 3'b110;
    localparam logic [2:0] OP_CLR     = 3'b111;

    state_t             state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   r0_q, r0_d;
    logic [WIDTH-1:0]   r1_q, r1_d;
    logic [WIDTH-1:0]   tmp_q, tmp_d;
    logic               sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_en;
    logic               done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cmd_q   <= OP_NOP;
            data_q  <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            tmp_q   <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            tmp_q   <= tmp_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // sel_d is the live select; sel_q only remembers it for cycles with the bus idle.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        tmp_d   = tmp_q;
        sel_d   = sel_q;
        bus_en  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    cmd_d   = CMD;
                    data_d  = FROM_BUS;
                    state_d = (CMD == OP_SWAP) ? SWAP_A : EXEC;
                end
            end
            EXEC: begin
                done    = 1'b1;
                state_d = IDLE;
                case (cmd_q)
                    OP_LOAD_R0: r0_d = data_q;
                    OP_LOAD_R1: r1_d = data_q;
                    OP_OUT_R0: begin
                        bus_en = 1'b1;
                        sel_d  = 1'b0;
                    end
                    OP_OUT_R1: begin
                        bus_en = 1'b1;
                        sel_d  = 1'b1;
                    end
                    OP_MOV: begin
                        bus_en = 1'b1;
                        sel_d  = 1'b0;
                        r1_d   = r0_q;
                    end
                    OP_CLR: begin
                        r0_d = '0;
                        r1_d = '0;
                    end
                    default: ;
                endcase
            end
            SWAP_A: begin
                tmp_d   = r0_q;
                r0_d    = r1_q;
                bus_en  = 1'b1;
                sel_d   = 1'b1;
                state_d = SWAP_B;
            end
            SWAP_B: begin
                r1_d    = tmp_q;
                bus_en  = 1'b1;
                sel_d   = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + CNT_W'(done);
    end

    assign CMD_READY = (state_q == IDLE);
    assign R0        = r0_q;
    assign R1        = r1_q;
    assign SEL_BUS   = sel_d;
    assign BUS_EN    = bus_en;
    assign DONE      = done;
    assign OP_COUNT  = cnt_q;

endmodule

// File: tb/tb_reg_bank_seq.sv
// Bench for reg_bank_seq: directed scenarios plus random command streams,
// compared against a register-level model of the command set.
module tb_reg_bank_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] FROM_BUS;
    logic        CMD_VALID;
    logic [2:0]  CMD;
    logic        CMD_READY;
    logic [15:0] R0, R1;
    logic        SEL_BUS, BUS_EN, DONE;
    logic [7:0]  OP_COUNT;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_r0, m_r1;
    logic        m_sel;
    int          m_cnt;

    reg_bank_seq #(.WIDTH(16), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .FROM_BUS(FROM_BUS), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .CMD_READY(CMD_READY), .R0(R0), .R1(R1), .SEL_BUS(SEL_BUS), .BUS_EN(BUS_EN),
        .DONE(DONE), .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_r0 = 16'h0; m_r1 = 16'h0; m_sel = 1'b0; m_cnt = 0;
    endtask

    // Drives one command from an IDLE negedge and checks every cycle until IDLE again.
    task automatic run_cmd(input logic [2:0] c, input logic [15:0] d, input string tag);
        logic exp_en, exp_sel;
        logic [15:0] tmp;
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++; $display("FAIL %s ready_before got %b want 1", tag, CMD_READY);
        end
        CMD = c; FROM_BUS = d; CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0; CMD = 3'($urandom); FROM_BUS = 16'($urandom);
        @(negedge CLK);
        if (c != 3'b110) begin
            exp_en  = (c == 3'b011) || (c == 3'b100) || (c == 3'b101);
            exp_sel = exp_en ? (c == 3'b100) : m_sel;
            checks++;
            if ({CMD_READY, DONE, BUS_EN, SEL_BUS} !== {1'b0, 1'b1, exp_en, exp_sel}) begin
                errors++;
                $display("FAIL %s exec rdy/done/en/sel got %b%b%b%b want 0 1 %b %b",
                         tag, CMD_READY, DONE, BUS_EN, SEL_BUS, exp_en, exp_sel);
            end
            checks++;
            if (OP_COUNT !== 8'(m_cnt)) begin
                errors++; $display("FAIL %s exec_count got %0d want %0d", tag, OP_COUNT, m_cnt);
            end
            case (c)
                3'b001: m_r0 = d;
                3'b010: m_r1 = d;
                3'b101: m_r1 = m_r0;
                3'b111: begin m_r0 = 16'h0; m_r1 = 16'h0; end
                default: ;
            endcase
            if (exp_en) m_sel = exp_sel;
        end else begin
            checks++;
            if ({CMD_READY, DONE, BUS_EN, SEL_BUS} !== 4'b0011) begin
                errors++;
                $display("FAIL %s swap_a rdy/done/en/sel got %b%b%b%b want 0011",
                         tag, CMD_READY, DONE, BUS_EN, SEL_BUS);
            end
            @(negedge CLK);
            checks++;
            if ({CMD_READY, DONE, BUS_EN, SEL_BUS, R0} !== {4'b0110, m_r1}) begin
                errors++;
                $display("FAIL %s swap_b rdy/done/en/sel/r0 got %b%b%b%b %h want 0110 %h",
                         tag, CMD_READY, DONE, BUS_EN, SEL_BUS, R0, m_r1);
            end
            tmp = m_r0; m_r0 = m_r1; m_r1 = tmp; m_sel = 1'b0;
        end
        m_cnt = (m_cnt + 1) % 256;
        @(negedge CLK);
        checks++;
        if ({CMD_READY, DONE, BUS_EN, SEL_BUS} !== {3'b100, m_sel}) begin
            errors++;
            $display("FAIL %s idle rdy/done/en/sel got %b%b%b%b want 100%b",
                     tag, CMD_READY, DONE, BUS_EN, SEL_BUS, m_sel);
        end
        checks++;
        if ({R0, R1, OP_COUNT} !== {m_r0, m_r1, 8'(m_cnt)}) begin
            errors++;
            $display("FAIL %s regs r0 %h r1 %h cnt %0d want %h %h %0d",
                     tag, R0, R1, OP_COUNT, m_r0, m_r1, m_cnt);
        end
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({CMD_READY, DONE, BUS_EN, SEL_BUS, R0, R1, OP_COUNT} !== {4'b1000, 16'h0, 16'h0, 8'h0}) begin
            errors++;
            $display("FAIL reset_state rdy/done/en/sel %b%b%b%b r0 %h r1 %h cnt %0d want 1000 0 0 0",
                     CMD_READY, DONE, BUS_EN, SEL_BUS, R0, R1, OP_COUNT);
        end
        // reset coincident with an accept drops the command
        RST = 1'b1; CMD = 3'b001; FROM_BUS = 16'hBEEF; CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if ({CMD_READY, DONE, R0, OP_COUNT} !== {2'b10, 16'h0, 8'h0}) begin
            errors++;
            $display("FAIL reset_vs_accept rdy %b done %b r0 %h cnt %0d want 1 0 0 0",
                     CMD_READY, DONE, R0, OP_COUNT);
        end
    endtask

    task automatic test_load();
        run_cmd(3'b001, 16'hA5A5, "load_r0");
        checks++;
        if (R0 !== 16'hA5A5 || OP_COUNT !== 8'd1) begin
            errors++; $display("FAIL load_r0_final r0 %h cnt %0d want a5a5 1", R0, OP_COUNT);
        end
    endtask

    task automatic test_out();
        run_cmd(3'b010, 16'h1234, "load_r1");
        run_cmd(3'b100, 16'h0000, "out_r1");
        checks++;
        if (SEL_BUS !== 1'b1 || BUS_EN !== 1'b0) begin
            errors++; $display("FAIL out_r1_hold sel %b en %b want 1 0", SEL_BUS, BUS_EN);
        end
        run_cmd(3'b011, 16'h0000, "out_r0");
    endtask

    task automatic test_swap();
        run_cmd(3'b001, 16'h0001, "swap_ld0");
        run_cmd(3'b010, 16'h0002, "swap_ld1");
        run_cmd(3'b110, 16'h0000, "swap");
        checks++;
        if (R0 !== 16'h0002 || R1 !== 16'h0001) begin
            errors++; $display("FAIL swap_result r0 %h r1 %h want 0002 0001", R0, R1);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        run_cmd(3'b001, 16'h5A5A, "b2b_ld0");
        base = m_cnt;
        CMD = 3'b101; CMD_VALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            FROM_BUS = 16'($urandom);
            @(negedge CLK);
            checks++;
            if ({CMD_READY, DONE} !== {(i % 2 == 1), (i % 2 == 0)} ||
                OP_COUNT !== 8'(base + (i + 1) / 2)) begin
                errors++;
                $display("FAIL b2b_cycle%0d rdy %b done %b cnt %0d want %b %b %0d", i,
                         CMD_READY, DONE, OP_COUNT, (i % 2 == 1), (i % 2 == 0), base + (i + 1) / 2);
            end
        end
        CMD_VALID = 1'b0;
        m_r1 = m_r0; m_sel = 1'b0; m_cnt = (base + 4) % 256;
        checks++;
        if (R1 !== 16'h5A5A || R0 !== 16'h5A5A) begin
            errors++; $display("FAIL b2b_mov r0 %h r1 %h want 5a5a 5a5a", R0, R1);
        end
    endtask

    task automatic test_reset_mid_swap();
        run_cmd(3'b001, 16'hFFFF, "rst_ld0");
        run_cmd(3'b010, 16'h0F0F, "rst_ld1");
        CMD = 3'b110; CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0; RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (SEL_BUS !== 1'b1 || BUS_EN !== 1'b1 || DONE !== 1'b0) begin
            errors++; $display("FAIL rst_swap_a sel %b en %b done %b want 1 1 0", SEL_BUS, BUS_EN, DONE);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        checks++;
        if ({R0, R1, OP_COUNT, CMD_READY, BUS_EN, SEL_BUS} !== {16'h0, 16'h0, 8'h0, 3'b100}) begin
            errors++;
            $display("FAIL rst_mid_swap r0 %h r1 %h cnt %0d rdy %b en %b sel %b want 0 0 0 1 0 0",
                     R0, R1, OP_COUNT, CMD_READY, BUS_EN, SEL_BUS);
        end
    endtask

    task automatic test_nop_wrap();
        apply_reset();
        run_cmd(3'b001, 16'hC3C3, "wrap_ld0");
        run_cmd(3'b010, 16'h3C3C, "wrap_ld1");
        for (int i = 0; i < 254; i++) run_cmd(3'b000, 16'($urandom), "nop");
        checks++;
        if (OP_COUNT !== 8'd0 || R0 !== 16'hC3C3 || R1 !== 16'h3C3C) begin
            errors++; $display("FAIL nop_wrap cnt %0d r0 %h r1 %h want 0 c3c3 3c3c", OP_COUNT, R0, R1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            run_cmd(3'($urandom), 16'($urandom), "rand");
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
    endtask

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD = 3'b000; FROM_BUS = 16'h0;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_load();
        test_out();
        test_swap();
        test_back_to_back();
        test_reset_mid_swap();
        test_nop_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_seq.md
Name: reg_bank_seq

Overview:
- Sequenced two-register bank that holds R0/R1 and drives SEL_BUS; it sits directly upstream of the register-to-bus output mux.
- It accepts one command at a time over a valid/ready handshake.
- Commands load registers from the incoming bus, present a register on the bus, move, swap or clear registers.
- Each completed command pulses DONE once and increments an operation counter.

Parameters:
- WIDTH, 16: data width of R0, R1, FROM_BUS and the swap temp register.
- CNT_W, 8: width of OP_COUNT.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- FROM_BUS  input  WIDTH  incoming bus data; sampled only when a command is accepted.
- CMD_VALID  input  1  command present.
- CMD  input  3  opcode (see Behaviour).
- CMD_READY  output  1  block can accept a command.
- R0  output  WIDTH  register 0 contents, feeds the output mux.
- R1  output  WIDTH  register 1 contents, feeds the output mux.
- SEL_BUS  output  1  mux select: 0 = R0, 1 = R1.
- BUS_EN  output  1  bus drive qualifier; high only while a register is being presented.
- DONE  output  1  one-cycle completion pulse.
- OP_COUNT  output  CNT_W  count of completed commands.

Behaviour:
- Reset: RST is sampled on the CLK edge. On reset:
  - state returns to IDLE;
  - R0, R1, TMP, latched data and OP_COUNT clear to 0;
  - SEL_BUS=0, BUS_EN=0, DONE=0, CMD_READY=1.
  - Reset overrides any command or operation in progress; a SWAP interrupted mid-way leaves both registers 0.
- Outputs: all outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Opcodes:
  - 000 NOP
  - 001 LOAD_R0
  - 010 LOAD_R1
  - 011 OUT_R0
  - 100 OUT_R1
  - 101 MOV_R0_R1 (R1<=R0)
  - 110 SWAP
  - 111 CLR
- Handshake:
  - A command is accepted at edge E0 when CMD_VALID=1 and CMD_READY=1.
  - At E0 the block latches CMD, latches FROM_BUS into an internal data register, and leaves IDLE.
  - CMD_READY is 1 only in IDLE.
  - CMD_VALID while not ready is ignored, with no queueing.
- States: IDLE, EXEC, SWAP_A, SWAP_B.
  - IDLE -> EXEC on accept, for all opcodes except SWAP.
  - IDLE -> SWAP_A on accept of SWAP.
  - EXEC -> IDLE after 1 cycle.
  - SWAP_A -> SWAP_B -> IDLE.
- EXEC cycle (the cycle after E0). Register writes occur at the end of this cycle (edge E1):
  - LOAD_Rx: Rx <= latched data.
  - OUT_Rx: SEL_BUS=x and BUS_EN=1 during EXEC.
  - MOV: SEL_BUS=0 and BUS_EN=1 during EXEC; R1 <= R0 at E1.
  - CLR: R0 <= 0 and R1 <= 0 at E1.
  - NOP: no register change.
  - DONE=1 during EXEC for every opcode.
- SWAP:
  - SWAP_A: TMP <= R0, R0 <= R1 at the end of the cycle; SEL_BUS=1, BUS_EN=1; DONE=0.
  - SWAP_B: R1 <= TMP at the end of the cycle; SEL_BUS=0, BUS_EN=1; DONE=1.
- SEL_BUS: holds its last driven value whenever BUS_EN=0.
- Latency and throughput:
  - Non-SWAP commands complete 1 cycle after accept.
  - SWAP completes 2 cycles after accept.
  - Maximum throughput is one non-SWAP command every 2 cycles, because IDLE is always revisited.
- OP_COUNT: increments by 1 on the edge that ends each DONE cycle. It wraps from 2^CNT_W-1 to 0 and does not saturate.
- Simultaneous events:
  - RST together with an accept: RST wins and the command is dropped.
  - FROM_BUS changes after E0 have no effect on a LOAD.

Test Plan:
- Reset then LOAD_R0 with FROM_BUS=16'hA5A5 -> CMD_READY=0 one cycle after accept; R0=16'hA5A5 and DONE=1 for exactly one cycle; OP_COUNT=1.
- LOAD_R1 16'h1234, then OUT_R1 -> during EXEC SEL_BUS=1, BUS_EN=1, DONE=1; next cycle BUS_EN=0 and SEL_BUS still 1.
- R0=16'h0001, R1=16'h0002, SWAP -> SWAP_A shows SEL_BUS=1, DONE=0; after SWAP_B R0=16'h0002, R1=16'h0001, single DONE pulse.
- Hold CMD_VALID=1 with MOV continuously -> accepts only on CMD_READY cycles (every 2 cycles); R1=R0 after first completion; FROM_BUS toggling has no effect.
- Assert RST during SWAP_A with R0=16'hFFFF, R1=16'h0F0F -> next cycle R0=R1=0, OP_COUNT=0, CMD_READY=1, BUS_EN=0.
- Issue 256 NOPs -> OP_COUNT wraps to 0 after the 256th DONE; R0 and R1 unchanged throughout.
